// File: rtl/register_update_sequencer.sv
// Hands register updates to a clock-crossing synchronizer one at a time.
// Keeps at most one newer value queued and re-issues transfers that are never acknowledged.
module register_update_sequencer #(
  parameter int unsigned      WIDTH   = 16,
  parameter logic [WIDTH-1:0] INIT    = '0,
  parameter int unsigned      TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  output logic             sync_en,
  output logic [WIDTH-1:0] sync_data,
  input  logic             sync_ack,
  output logic             busy,
  output logic             pending,
  output logic [7:0]       coalesce_count,
  output logic [7:0]       timeout_count
);

  localparam int unsigned TW = $clog2(TIMEOUT + 2);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT);

  typedef enum logic {
    S_IDLE,
    S_WAIT
  } state_t;

  state_t           state;
  state_t           state_nx;
  logic             en_q;
  logic             en_nx;
  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] data_nx;
  logic [WIDTH-1:0] pdata_q;
  logic [WIDTH-1:0] pdata_nx;
  logic             pend_q;
  logic             pend_nx;
  logic [TW-1:0]    timer_q;
  logic [TW-1:0]    timer_nx;
  logic [7:0]       ccnt_q;
  logic [7:0]       ccnt_nx;
  logic [7:0]       tcnt_q;
  logic [7:0]       tcnt_nx;

  logic in_wait;
  logic ack_v;
  logic tmo;
  logic idle_wr;
  logic ack_wr;
  logic ack_pend;
  logic ack_done;
  logic wait_hold;

  // An ack landing on the launch cycle cannot belong to that transfer.
  assign in_wait   = (state == S_WAIT);
  assign ack_v     = in_wait && sync_ack && !en_q;
  assign tmo       = (TIMEOUT != 0) && in_wait &&
                     !ack_v && (timer_q == TMAX);
  assign idle_wr   = !in_wait && wr_en;
  assign ack_wr    = ack_v && wr_en;
  assign ack_pend  = ack_v && !wr_en && pend_q;
  assign ack_done  = ack_v && !wr_en && !pend_q;
  assign wait_hold = in_wait && !ack_v;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      en_q    <= 1'b0;
      data_q  <= INIT;
      pdata_q <= INIT;
      pend_q  <= 1'b0;
      timer_q <= '0;
      ccnt_q  <= '0;
      tcnt_q  <= '0;
    end else begin
      state   <= state_nx;
      en_q    <= en_nx;
      data_q  <= data_nx;
      pdata_q <= pdata_nx;
      pend_q  <= pend_nx;
      timer_q <= timer_nx;
      ccnt_q  <= ccnt_nx;
      tcnt_q  <= tcnt_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE: if (wr_en) state_nx = S_WAIT;
      S_WAIT: if (ack_done) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    en_nx    = 1'b0;
    data_nx  = data_q;
    pdata_nx = pdata_q;
    pend_nx  = pend_q;
    timer_nx = timer_q;
    ccnt_nx  = ccnt_q;
    tcnt_nx  = tcnt_q;
    unique case (1'b1)
      idle_wr: begin
        en_nx    = 1'b1;
        data_nx  = wr_data;
        timer_nx = '0;
      end
      ack_wr: begin
        en_nx    = 1'b1;
        data_nx  = wr_data;
        pend_nx  = 1'b0;
        timer_nx = '0;
        if (pend_q && ccnt_q != 8'hFF)
          ccnt_nx = ccnt_q + 8'd1;
      end
      ack_pend: begin
        en_nx    = 1'b1;
        data_nx  = pdata_q;
        pend_nx  = 1'b0;
        timer_nx = '0;
      end
      ack_done: begin
        timer_nx = '0;
      end
      wait_hold: begin
        if (wr_en) begin
          pdata_nx = wr_data;
          pend_nx  = 1'b1;
          if (pend_q && ccnt_q != 8'hFF)
            ccnt_nx = ccnt_q + 8'd1;
        end
        // Re-issue the same value; a queued value waits for a real ack.
        if (tmo) begin
          en_nx    = 1'b1;
          timer_nx = '0;
          if (tcnt_q != 8'hFF)
            tcnt_nx = tcnt_q + 8'd1;
        end else begin
          timer_nx = timer_q + 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign sync_en        = en_q;
  assign sync_data      = data_q;
  assign busy           = in_wait;
  assign pending        = pend_q;
  assign coalesce_count = ccnt_q;
  assign timeout_count  = tcnt_q;

endmodule

// File: tb/tb_register_update_sequencer.sv
// Bench for register_update_sequencer: a no-timeout instance with a
// launch scoreboard, and a TIMEOUT=8 instance for re-issue behaviour.
module tb_register_update_sequencer;

  localparam logic [15:0] M_INIT = 16'h1357;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en;
  logic [15:0] wr_data;
  logic        ack_m;
  logic        ack_t;

  logic        m_en, m_busy, m_pend;
  logic [15:0] m_data;
  logic [7:0]  m_ccnt, m_tcnt;
  logic        t_en, t_busy, t_pend;
  logic [15:0] t_data;
  logic [7:0]  t_ccnt, t_tcnt;

  int          n_chk = 0;
  int          n_err = 0;
  logic [15:0] exp_q[$];
  bit          prev_en = 1'b0;

  always #5 clk = ~clk;

  register_update_sequencer #(
    .WIDTH(16), .INIT(M_INIT), .TIMEOUT(0)
  ) u_dut (
    .clk(clk), .rst(rst),
    .wr_en(wr_en), .wr_data(wr_data),
    .sync_en(m_en), .sync_data(m_data),
    .sync_ack(ack_m), .busy(m_busy),
    .pending(m_pend),
    .coalesce_count(m_ccnt),
    .timeout_count(m_tcnt)
  );

  register_update_sequencer #(
    .WIDTH(16), .INIT(16'h0000), .TIMEOUT(8)
  ) u_to (
    .clk(clk), .rst(rst),
    .wr_en(wr_en), .wr_data(wr_data),
    .sync_en(t_en), .sync_data(t_data),
    .sync_ack(ack_t), .busy(t_busy),
    .pending(t_pend),
    .coalesce_count(t_ccnt),
    .timeout_count(t_tcnt)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [15:0] d);
    wr_en   = 1'b1;
    wr_data = d;
    step();
    wr_en   = 1'b0;
  endtask

  task automatic ackm();
    ack_m = 1'b1;
    step();
    ack_m = 1'b0;
  endtask

  task automatic ackt();
    ack_t = 1'b1;
    step();
    ack_t = 1'b0;
  endtask

  // Every launch of the main instance must match the next queued value.
  always @(negedge clk) begin
    if (rst) begin
      prev_en = 1'b0;
    end else begin
      check("en_consec", {31'd0, prev_en && m_en}, 0);
      if (m_en) begin
        if (exp_q.size() == 0)
          check("sync_en_spurious", 1, 0);
        else
          check("sync_data", {16'd0, m_data},
                {16'd0, exp_q.pop_front()});
      end
      prev_en = m_en;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    wr_en = 1'b0;
    wr_data = '0;
    ack_m = 1'b0;
    ack_t = 1'b0;
    step();
    step();
    rst = 1'b0;
    check("rst_busy", m_busy, 0);
    check("rst_en", m_en, 0);
    check("rst_data", m_data, M_INIT);
    check("rst_pend", m_pend, 0);
    check("rst_ccnt", m_ccnt, 0);
    check("rst_tcnt", m_tcnt, 0);

    // stray ack while idle
    ackm();
    check("idle_ack_en", m_en, 0);
    check("idle_ack_busy", m_busy, 0);

    // single transfer
    exp_q.push_back(16'h1234);
    wr(16'h1234);
    check("x1_en", m_en, 1);
    check("x1_busy", m_busy, 1);
    check("x1_data", m_data, 16'h1234);
    step();
    check("x1_en_low", m_en, 0);
    repeat (7) step();
    check("x1_hold", m_data, 16'h1234);
    ackm();
    check("x1_done", m_busy, 0);
    check("x1_no_tmo", m_tcnt, 0);

    // coalesce then ack
    exp_q.push_back(16'h1111);
    wr(16'h1111);
    step();
    wr(16'hAAAA);
    check("co_pend", m_pend, 1);
    check("co_cnt0", m_ccnt, 0);
    wr(16'hBBBB);
    check("co_cnt1", m_ccnt, 1);
    exp_q.push_back(16'hBBBB);
    ackm();
    check("co_en", m_en, 1);
    check("co_pend0", m_pend, 0);
    step();
    ackm();
    check("co_idle", m_busy, 0);

    // ack with simultaneous write, newest wins
    exp_q.push_back(16'h2222);
    wr(16'h2222);
    step();
    wr(16'hDDDD);
    exp_q.push_back(16'hCCCC);
    ack_m = 1'b1;
    wr(16'hCCCC);
    ack_m = 1'b0;
    check("aw_en", m_en, 1);
    check("aw_data", m_data, 16'hCCCC);
    check("aw_cnt", m_ccnt, 2);
    check("aw_pend", m_pend, 0);
    step();
    ackm();
    check("aw_idle", m_busy, 0);

    // ack on the launch cycle is ignored
    exp_q.push_back(16'h3333);
    wr(16'h3333);
    ackm();
    check("ign_busy", m_busy, 1);
    ackm();
    check("ign_idle", m_busy, 0);

    // reset mid-wait with a pending value
    exp_q.push_back(16'h4444);
    wr(16'h4444);
    step();
    wr(16'h5555);
    wr(16'h5656);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mr_busy", m_busy, 0);
    check("mr_en", m_en, 0);
    check("mr_data", m_data, M_INIT);
    check("mr_pend", m_pend, 0);
    check("mr_ccnt", m_ccnt, 0);
    ackm();
    check("mr_stray_en", m_en, 0);
    check("mr_stray_busy", m_busy, 0);
    exp_q.push_back(16'h6666);
    wr(16'h6666);
    step();
    ackm();
    check("mr_no_old", m_busy, 0);

    // saturating coalesce counter
    exp_q.push_back(16'h7777);
    wr(16'h7777);
    for (int i = 1; i <= 300; i++) begin
      wr_en   = 1'b1;
      wr_data = 16'(i);
      step();
    end
    wr_en = 1'b0;
    check("sat_ccnt", m_ccnt, 255);
    check("sat_pend", m_pend, 1);
    exp_q.push_back(16'd300);
    ackm();
    check("sat_en", m_en, 1);
    step();
    ackm();
    check("sat_idle", m_busy, 0);

    // timeout re-issue on the TIMEOUT=8 instance
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("to_rst_tcnt", t_tcnt, 0);
    exp_q.push_back(16'h8888);
    wr(16'h8888);
    check("to_first", t_en, 1);
    for (int r = 1; r <= 3; r++) begin
      for (int k = 1; k <= 9; k++) begin
        if (r == 1 && k == 1) begin
          wr_en   = 1'b1;
          wr_data = 16'h9999;
        end
        step();
        wr_en = 1'b0;
        if (k < 9) begin
          check("to_quiet", t_en, 0);
        end else begin
          check("to_reissue", t_en, 1);
          check("to_data", t_data, 16'h8888);
          check("to_tcnt", t_tcnt, r);
        end
      end
    end
    check("to_pend", t_pend, 1);
    check("m_pend_kept", m_pend, 1);
    step();
    ackt();
    check("to_ack_en", t_en, 1);
    check("to_ack_data", t_data, 16'h9999);
    check("to_ack_pend", t_pend, 0);
    step();
    ackt();
    check("to_idle", t_busy, 0);

    exp_q.push_back(16'h9999);
    ackm();
    check("m_pend_clr", m_pend, 0);
    step();
    ackm();
    check("m_end_idle", m_busy, 0);
    check("m_tcnt_off", m_tcnt, 0);

    step();
    check("q_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
